// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared MMIO offsets, STATUS bit indices and byte-lane helpers
package data_mem_pkg;

  localparam logic [1:0] OFF_LED    = 2'd0;
  localparam logic [1:0] OFF_COUNT  = 2'd1;
  localparam logic [1:0] OFF_CMP    = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int HIT_BIT = 0;
  localparam int IEN_BIT = 1;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  // sel[k] enables data[k*8 +: 8]; sel[3] is the big-endian byte at offset 0
  function automatic logic [31:0] lane_mask(input logic [NUM_LANES-1:0] sel);
    logic [31:0] mask;
    mask = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      mask[k*LANE_W +: LANE_W] = {LANE_W{sel[k]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - LED latch, free-running counter, compare and sticky timer status
module mmio_timer
  import data_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [1:0]  off,
  input  logic [3:0]  sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [15:0] led,
  output logic        irq
);

  logic [31:0] count;
  logic [31:0] cmp;
  logic [15:0] led_q;
  logic        hit;
  logic        ien;

  logic [31:0] mask;
  logic        wr_led, wr_count, wr_cmp, wr_status;
  logic        hit_set, hit_clr;

  assign mask      = lane_mask(sel);
  assign wr_led    = wr && (off == OFF_LED);
  assign wr_count  = wr && (off == OFF_COUNT);
  assign wr_cmp    = wr && (off == OFF_CMP);
  assign wr_status = wr && (off == OFF_STATUS);

  // match uses the pre-increment count; CMP==0 disables matching
  assign hit_set = (cmp != '0) && (count == cmp);
  assign hit_clr = wr_status && sel[0] && wdata[HIT_BIT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      cmp   <= '0;
      led_q <= '0;
      hit   <= 1'b0;
      ien   <= 1'b0;
    end else begin
      count <= (wr_count && (sel != '0)) ? '0 : count + 32'd1;
      if (wr_led) led_q <= (led_q & ~mask[15:0]) | (wdata[15:0] & mask[15:0]);
      if (wr_cmp) cmp <= (cmp & ~mask) | (wdata & mask);
      if (wr_status && sel[0]) ien <= wdata[IEN_BIT];
      if (hit_set) hit <= 1'b1;
      else if (hit_clr) hit <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_LED:    rdata = {16'h0000, led_q};
      OFF_COUNT:  rdata = count;
      OFF_CMP:    rdata = cmp;
      OFF_STATUS: rdata = {30'h0, ien, hit};
      default:    rdata = '0;
    endcase
  end

  assign led = led_q;
  assign irq = hit & ien;

endmodule

// File: rtl/data_mem_mmio.sv
// rtl/data_mem_mmio.sv - data-side word RAM with byte-lane writes plus MMIO timer window
module data_mem_mmio
  import data_mem_pkg::*;
#(
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] data_o,
  output logic [15:0] led_o,
  output logic        timer_irq_o
);

  logic [31:0]       mem [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic              mmio_hit;
  logic              ram_wr;
  logic              mmio_wr;
  logic [31:0]       mmio_rdata;
  logic              unused_addr_bits;

  assign mmio_hit = (addr_i[31:4] == MMIO_BASE[31:4]);
  assign ram_idx  = addr_i[RAM_AW+1:2];
  assign ram_wr   = ce_i && we_i && !mmio_hit;
  assign mmio_wr  = ce_i && we_i && mmio_hit;

  // byte offset within the word never matters; lanes come from sel_i alone
  assign unused_addr_bits = ^addr_i[1:0];

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (sel_i[k]) mem[ram_idx][k*LANE_W +: LANE_W] <= data_i[k*LANE_W +: LANE_W];
      end
    end
  end

  mmio_timer u_mmio_timer (
    .clk   (clk),
    .rst   (rst),
    .wr    (mmio_wr),
    .off   (addr_i[3:2]),
    .sel   (sel_i),
    .wdata (data_i),
    .rdata (mmio_rdata),
    .led   (led_o),
    .irq   (timer_irq_o)
  );

  always_comb begin
    data_o = '0;
    if (rst && ce_i && !we_i) begin
      data_o = mmio_hit ? mmio_rdata : mem[ram_idx];
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// tb/tb_data_mem_mmio.sv - scoreboard bench for data_mem_mmio against a behavioural model
module tb_data_mem_mmio;

  localparam logic [31:0] MB = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [3:0]  sel_i = '0;
  logic [31:0] data_o;
  logic [15:0] led_o;
  logic        timer_irq_o;

  always #5 clk = ~clk;

  data_mem_mmio #(.RAM_AW(10), .MMIO_BASE(MB)) dut (
    .clk         (clk),
    .rst         (rst),
    .ce_i        (ce_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .sel_i       (sel_i),
    .data_o      (data_o),
    .led_o       (led_o),
    .timer_irq_o (timer_irq_o)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [15:0] led;
    logic        irq;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // reference model: RAM array, register values, count as elapsed cycles since last clear
  bit [31:0] rm [1024];
  bit [15:0] m_led;
  bit [31:0] m_cmp;
  bit        m_hit;
  bit        m_ien;
  longint    cyc = 0;
  longint    base = 0;

  function automatic bit [31:0] m_count();
    return 32'(cyc - base);
  endfunction

  function automatic bit [31:0] lanes(bit [31:0] old_v, bit [31:0] new_v, bit [3:0] s);
    bit [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++) if (s[k]) r[k*8 +: 8] = new_v[k*8 +: 8];
    return r;
  endfunction

  task automatic check(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      check({mon_e.name, ".data"}, data_o, mon_e.data);
      check({mon_e.name, ".led"}, {16'h0, led_o}, {16'h0, mon_e.led});
      check({mon_e.name, ".irq"}, {31'h0, timer_irq_o}, {31'h0, mon_e.irq});
    end
  end

  task automatic model_reset();
    m_led = '0;
    m_cmp = '0;
    m_hit = 1'b0;
    m_ien = 1'b0;
    base  = cyc;
  endtask

  task automatic op(string name, bit ce, bit we, bit [31:0] a, bit [31:0] d, bit [3:0] s);
    exp_t      e;
    bit [31:0] exp_d, cnt, tmp;
    bit        mm, hit_next;
    int        idx;
    ce_i = ce; we_i = we; addr_i = a; data_i = d; sel_i = s;
    mm  = (a[31:4] == MB[31:4]);
    idx = int'(a[11:2]);
    cnt = m_count();
    exp_d = '0;
    if (ce && !we) begin
      if (mm) begin
        case (a[3:2])
          2'd0: exp_d = {16'h0, m_led};
          2'd1: exp_d = cnt;
          2'd2: exp_d = m_cmp;
          default: exp_d = {30'h0, m_ien, m_hit};
        endcase
      end else begin
        exp_d = rm[idx];
      end
    end
    e.name = name; e.data = exp_d; e.led = m_led; e.irq = m_hit & m_ien;
    sbq.push_back(e);
    @(posedge clk);
    if (m_cmp != 0 && cnt == m_cmp) hit_next = 1'b1;
    else if (ce && we && mm && a[3:2] == 2'd3 && s[0] && d[0]) hit_next = 1'b0;
    else hit_next = m_hit;
    cyc++;
    if (ce && we) begin
      if (mm) begin
        case (a[3:2])
          2'd0: begin tmp = lanes({16'h0, m_led}, d, s); m_led = tmp[15:0]; end
          2'd1: if (s != 0) base = cyc;
          2'd2: m_cmp = lanes(m_cmp, d, s);
          default: if (s[0]) m_ien = d[1];
        endcase
      end else begin
        rm[idx] = lanes(rm[idx], d, s);
      end
    end
    m_hit = hit_next;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] a, d;
    bit        we, ce;
    int        r;

    rst = 1'b0;
    ce_i = 1'b1; addr_i = MB + 32'h4;
    repeat (3) @(posedge clk);
    #1;
    check("reset.data", data_o, 32'h0);
    check("reset.led", {16'h0, led_o}, 32'h0);
    check("reset.irq", {31'h0, timer_irq_o}, 32'h0);
    rst = 1'b1;
    model_reset();

    op("ram_full_wr", 1, 1, 32'h0, 32'hDEADBEEF, 4'hF);
    op("ram_full_rd", 1, 0, 32'h0, 32'h0, 4'h0);

    op("byte_pre", 1, 1, 32'h10, 32'h11223344, 4'hF);
    op("byte_hi_wr", 1, 1, 32'h10, 32'hAA000000, 4'b1000);
    op("byte_hi_rd", 1, 0, 32'h10, 32'h0, 4'h1);
    op("byte_lo_wr", 1, 1, 32'h13, 32'h000000BB, 4'b0001);
    op("byte_lo_rd", 1, 0, 32'h10, 32'h0, 4'h0);
    op("sel0_wr", 1, 1, 32'h10, 32'hFFFFFFFF, 4'h0);
    op("sel0_rd", 1, 0, 32'h12, 32'h0, 4'hF);

    op("alias_wr", 1, 1, 32'h1004, 32'h5555AAAA, 4'hF);
    op("alias_rd", 1, 0, 32'h4, 32'h0, 4'hF);
    op("ce0_rd", 0, 0, 32'h4, 32'h0, 4'hF);
    op("we_rd", 1, 1, 32'h4, 32'h5555AAAA, 4'h0);

    op("led_wr", 1, 1, MB, 32'h1234BEEF, 4'hF);
    op("led_rd", 1, 0, MB, 32'h0, 4'hF);
    op("cnt_clr", 1, 1, MB + 32'h4, 32'hFFFF, 4'h2);
    for (int i = 0; i < 7; i++) op("cnt_rd", 1, 0, MB + 32'h4, 32'h0, 4'h0);

    op("ien_wr", 1, 1, MB + 32'hC, 32'h2, 4'h1);
    op("cmp_wr", 1, 1, MB + 32'h8, 32'd20, 4'hF);
    op("cnt_clr2", 1, 1, MB + 32'h4, 32'h0, 4'hF);
    for (int i = 0; i < 25; i++) op("irq_wait", 1, 0, MB + 32'hC, 32'h0, 4'h0);
    op("w1c", 1, 1, MB + 32'hC, 32'h3, 4'h1);
    for (int i = 0; i < 3; i++) op("after_w1c", 1, 0, MB + 32'hC, 32'h0, 4'h0);

    op("cnt_clr3", 1, 1, MB + 32'h4, 32'h0, 4'hF);
    while (m_count() != 32'd20) op("race_wait", 1, 0, MB + 32'h4, 32'h0, 4'h0);
    op("race_w1c", 1, 1, MB + 32'hC, 32'h3, 4'h1);
    for (int i = 0; i < 3; i++) op("race_rd", 1, 0, MB + 32'hC, 32'h0, 4'h0);
    op("w1c2", 1, 1, MB + 32'hC, 32'h3, 4'h1);
    op("cmp0_wr", 1, 1, MB + 32'h8, 32'h0, 4'hF);
    op("cnt_clr4", 1, 1, MB + 32'h4, 32'h0, 4'hF);
    for (int i = 0; i < 5; i++) op("cmp0_rd", 1, 0, MB + 32'hC, 32'h0, 4'h0);

    op("cmp5_wr", 1, 1, MB + 32'h8, 32'd5, 4'hF);
    op("cnt_clr5", 1, 1, MB + 32'h4, 32'h0, 4'hF);
    for (int i = 0; i < 10; i++) op("pre_rst", 1, 0, MB + 32'h4, 32'h0, 4'h0);
    ce_i = 1'b1; we_i = 1'b1; addr_i = MB; data_i = 32'hFFFF; sel_i = 4'hF;
    #2 rst = 1'b0;
    #1;
    check("midrst.data", data_o, 32'h0);
    check("midrst.led", {16'h0, led_o}, 32'h0);
    check("midrst.irq", {31'h0, timer_irq_o}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    op("post_rst_cnt", 1, 0, MB + 32'h4, 32'h0, 4'h0);
    op("post_rst_led", 1, 0, MB, 32'h0, 4'h0);

    for (int i = 0; i < 16; i++) op("rnd_init", 1, 1, 32'(i * 4), $urandom, 4'hF);
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 9);
      we = 1'($urandom_range(0, 1));
      ce = ($urandom_range(0, 7) != 0);
      if (r < 5) begin
        a = 32'($urandom_range(0, 3) * 4096 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        op("rnd_ram", ce, we, a, $urandom, 4'($urandom_range(0, 15)));
      end else begin
        a = MB + 32'($urandom_range(0, 3) * 4 + $urandom_range(0, 3));
        d = (a[3:2] == 2'd2) ? 32'($urandom_range(0, 60)) : $urandom;
        if (a[3:2] == 2'd1 && we && $urandom_range(0, 3) != 0) we = 1'b0;
        op("rnd_mmio", ce, we, a, d, 4'($urandom_range(0, 15)));
      end
    end

    ce_i = 1'b0; we_i = 1'b0;
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
